// File: rtl/morse_symbol_decoder.sv
// Morse symbol decoder: collects dot/dash pulses and emits a 6-bit symbol code plus a legacy one-hot letter.
// Optional word-gap space emission is enabled by defining MORSE_WORD_GAP_EN.
module morse_symbol_decoder #(
  parameter int unsigned MAX_SYMS        = 5,
  parameter int unsigned GAP_CYCLES      = 12500000,
  parameter int unsigned WORD_GAP_CYCLES = 37500000
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic        L,
  input  logic        S,
  output logic [5:0]  code,
  output logic        code_valid,
  output logic        code_err,
  output logic [25:0] letter_onehot,
  output logic        busy
);

  localparam int unsigned CNT_W = $clog2(MAX_SYMS + 1);
  localparam int unsigned GAP_W = $clog2(WORD_GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [GAP_W-1:0] WGAP_LAST  = GAP_W'(WORD_GAP_CYCLES - 1);
  localparam logic [5:0]       CODE_SPACE = 6'd36;
`endif
  localparam logic [5:0] CODE_BAD = 6'd63;

  typedef enum logic [1:0] {IDLE, COLLECT, EMIT, WGAP} state_t;

  state_t               state_q;
  logic [MAX_SYMS-1:0]  sym_bits_q;
  logic [CNT_W-1:0]     sym_cnt_q;
  logic                 ovf_q;
  logic [GAP_W-1:0]     gap_cnt_q;
  logic                 pend_q;
  logic                 pend_dash_q;

  logic                 sym_v;
  logic [GAP_W-1:0]     gap_inc_d;
  logic [5:0]           dec_code_d;
  logic [25:0]          dec_onehot_d;

  assign sym_v     = L | S;
  assign gap_inc_d = (gap_cnt_q == '1) ? gap_cnt_q : gap_cnt_q + 1'b1;

  // Pattern lookup: first symbol is the MSB of the stored bits, dash = 1.
  always_comb begin
    dec_code_d = CODE_BAD;
    if (!ovf_q) begin
      case ({3'(sym_cnt_q), 6'(sym_bits_q)})
        {3'd1, 6'b000000}: dec_code_d = 6'd4;
        {3'd1, 6'b000001}: dec_code_d = 6'd19;
        {3'd2, 6'b000001}: dec_code_d = 6'd0;
        {3'd2, 6'b000000}: dec_code_d = 6'd8;
        {3'd2, 6'b000011}: dec_code_d = 6'd12;
        {3'd2, 6'b000010}: dec_code_d = 6'd13;
        {3'd3, 6'b000100}: dec_code_d = 6'd3;
        {3'd3, 6'b000110}: dec_code_d = 6'd6;
        {3'd3, 6'b000101}: dec_code_d = 6'd10;
        {3'd3, 6'b000111}: dec_code_d = 6'd14;
        {3'd3, 6'b000010}: dec_code_d = 6'd17;
        {3'd3, 6'b000000}: dec_code_d = 6'd18;
        {3'd3, 6'b000001}: dec_code_d = 6'd20;
        {3'd3, 6'b000011}: dec_code_d = 6'd22;
        {3'd4, 6'b001000}: dec_code_d = 6'd1;
        {3'd4, 6'b001010}: dec_code_d = 6'd2;
        {3'd4, 6'b000010}: dec_code_d = 6'd5;
        {3'd4, 6'b000000}: dec_code_d = 6'd7;
        {3'd4, 6'b000111}: dec_code_d = 6'd9;
        {3'd4, 6'b000100}: dec_code_d = 6'd11;
        {3'd4, 6'b000110}: dec_code_d = 6'd15;
        {3'd4, 6'b001101}: dec_code_d = 6'd16;
        {3'd4, 6'b000001}: dec_code_d = 6'd21;
        {3'd4, 6'b001001}: dec_code_d = 6'd23;
        {3'd4, 6'b001011}: dec_code_d = 6'd24;
        {3'd4, 6'b001100}: dec_code_d = 6'd25;
        {3'd5, 6'b011111}: dec_code_d = 6'd26;
        {3'd5, 6'b001111}: dec_code_d = 6'd27;
        {3'd5, 6'b000111}: dec_code_d = 6'd28;
        {3'd5, 6'b000011}: dec_code_d = 6'd29;
        {3'd5, 6'b000001}: dec_code_d = 6'd30;
        {3'd5, 6'b000000}: dec_code_d = 6'd31;
        {3'd5, 6'b010000}: dec_code_d = 6'd32;
        {3'd5, 6'b011000}: dec_code_d = 6'd33;
        {3'd5, 6'b011100}: dec_code_d = 6'd34;
        {3'd5, 6'b011110}: dec_code_d = 6'd35;
        default:           dec_code_d = CODE_BAD;
      endcase
    end
  end

  always_comb begin
    dec_onehot_d = '0;
    if (dec_code_d < 6'd26) dec_onehot_d[5'd25 - 5'(dec_code_d)] = 1'b1;
  end

  // Symbol collection, gap timing and emit sequencing; everything freezes while Start is low.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q       <= IDLE;
      sym_bits_q    <= '0;
      sym_cnt_q     <= '0;
      ovf_q         <= 1'b0;
      gap_cnt_q     <= '0;
      pend_q        <= 1'b0;
      pend_dash_q   <= 1'b0;
      code          <= '0;
      code_valid    <= 1'b0;
      code_err      <= 1'b0;
      letter_onehot <= '0;
      busy          <= 1'b0;
    end else if (!Start) begin
      code_valid <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      case (state_q)
        IDLE: begin
          if (sym_v) begin
            state_q    <= COLLECT;
            busy       <= 1'b1;
            sym_cnt_q  <= CNT_W'(1);
            sym_bits_q <= MAX_SYMS'(L);
            gap_cnt_q  <= '0;
          end
        end
        COLLECT: begin
          if (gap_cnt_q == GAP_LAST) begin
            // A symbol colliding with gap expiry is parked and opens the next character.
            state_q     <= EMIT;
            busy        <= 1'b0;
            pend_q      <= sym_v;
            pend_dash_q <= L;
          end else if (sym_v) begin
            gap_cnt_q <= '0;
            if (sym_cnt_q == CNT_W'(MAX_SYMS)) begin
              ovf_q <= 1'b1;
            end else begin
              sym_cnt_q  <= sym_cnt_q + 1'b1;
              sym_bits_q <= {sym_bits_q[MAX_SYMS-2:0], L};
            end
          end else begin
            gap_cnt_q <= gap_inc_d;
          end
        end
        EMIT: begin
          code          <= dec_code_d;
          code_err      <= (dec_code_d == CODE_BAD);
          letter_onehot <= dec_onehot_d;
          code_valid    <= 1'b1;
          ovf_q         <= 1'b0;
          gap_cnt_q     <= '0;
          pend_q        <= 1'b0;
          sym_cnt_q     <= '0;
          sym_bits_q    <= '0;
          if (pend_q) begin
            state_q <= COLLECT;
            busy    <= 1'b1;
            if (sym_v) begin
              sym_cnt_q  <= CNT_W'(2);
              sym_bits_q <= MAX_SYMS'({pend_dash_q, L});
            end else begin
              sym_cnt_q  <= CNT_W'(1);
              sym_bits_q <= MAX_SYMS'(pend_dash_q);
            end
          end else if (sym_v) begin
            state_q    <= COLLECT;
            busy       <= 1'b1;
            sym_cnt_q  <= CNT_W'(1);
            sym_bits_q <= MAX_SYMS'(L);
          end else begin
`ifdef MORSE_WORD_GAP_EN
            state_q <= WGAP;
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef MORSE_WORD_GAP_EN
        WGAP: begin
          if (sym_v) begin
            state_q    <= COLLECT;
            busy       <= 1'b1;
            sym_cnt_q  <= CNT_W'(1);
            sym_bits_q <= MAX_SYMS'(L);
            gap_cnt_q  <= '0;
          end else if (gap_cnt_q == WGAP_LAST) begin
            state_q       <= IDLE;
            code          <= CODE_SPACE;
            code_err      <= 1'b0;
            letter_onehot <= '0;
            code_valid    <= 1'b1;
          end else begin
            gap_cnt_q <= gap_inc_d;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
